// File: rtl/fas_sched.sv
// fas_sched: ping-pong frame buffer writer and FFT/analysis launch scheduler.
// Define FAS_SCHED_WDOG_EN to abort stuck FFT/analysis runs after WDOG_MAX cycles.
module fas_sched #(
   parameter int NUM_FRAMES = 64,
   parameter int WDOG_MAX   = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        fir_valid,
   input  logic [15:0] fir_d,
   output logic        buf_wr_en,
   output logic [4:0]  buf_wr_addr,
   output logic [15:0] buf_wr_data,
   output logic        fft_start,
   output logic        fft_bank,
   input  logic        fft_done,
   output logic        ana_start,
   input  logic        ana_done,
   output logic [6:0]  frame_cnt,
   output logic        done,
   output logic        overflow,
   output logic        err
);
   typedef enum logic [1:0] {IDLE, FFT_RUN, ANA_RUN, DONE} state_t;
   state_t state_q, state_d;
   logic [3:0] wptr_q, wptr_d;
   logic [1:0] full_q, full_d;
   logic [6:0] frame_cnt_q, frame_cnt_d;
   logic wbank_q, wbank_d, rbank_q, rbank_d, done_q, done_d, overflow_q, overflow_d;
   logic fft_start_q, fft_start_d, ana_start_q, ana_start_d, fft_bank_q, fft_bank_d;
   logic wr_ok, frame_end, release_bank;
`ifdef FAS_SCHED_WDOG_EN
   localparam int WW = $clog2(WDOG_MAX + 1);
   logic [WW-1:0] wdog_q, wdog_d;
   logic err_q, err_d, run;
   assign err = err_q;
`else
   assign err = 1'b0;
`endif
   assign wr_ok       = fir_valid && !full_q[wbank_q];
   assign frame_end   = wr_ok && wptr_q == 4'hf;
   assign buf_wr_en   = wr_ok;
   assign buf_wr_addr = {wbank_q, wptr_q};
   assign buf_wr_data = fir_d;
   assign fft_start   = fft_start_q;
   assign fft_bank    = fft_bank_q;
   assign ana_start   = ana_start_q;
   assign frame_cnt   = frame_cnt_q;
   assign done        = done_q;
   assign overflow    = overflow_q;
   always_comb begin
      wptr_d       = wr_ok ? wptr_q + 4'd1 : wptr_q;
      wbank_d      = frame_end ? ~wbank_q : wbank_q;
      overflow_d   = overflow_q | (fir_valid & full_q[wbank_q]);
      full_d       = full_q;
      full_d[wbank_q] = full_q[wbank_q] | frame_end;
      state_d      = state_q;
      rbank_d      = rbank_q;
      frame_cnt_d  = frame_cnt_q;
      fft_start_d  = 1'b0;
      ana_start_d  = 1'b0;
      fft_bank_d   = fft_bank_q;
      release_bank = 1'b0;
      case (state_q)
         IDLE: if (full_d[rbank_q]) begin
            state_d     = FFT_RUN;
            fft_start_d = 1'b1;
            fft_bank_d  = rbank_q;
         end
         FFT_RUN: if (fft_done) begin
            state_d     = ANA_RUN;
            ana_start_d = 1'b1;
         end
         ANA_RUN: if (ana_done) begin
            release_bank = 1'b1;
            frame_cnt_d  = frame_cnt_q == 7'(NUM_FRAMES) ? frame_cnt_q : frame_cnt_q + 7'd1;
            state_d      = frame_cnt_q + 7'd1 == 7'(NUM_FRAMES) ? DONE : IDLE;
         end
         DONE: state_d = DONE;
      endcase
`ifdef FAS_SCHED_WDOG_EN
      run   = state_q == FFT_RUN || state_q == ANA_RUN;
      err_d = run && state_d == state_q && wdog_q == WW'(WDOG_MAX - 1);
      if (err_d) begin
         state_d      = IDLE;
         release_bank = 1'b1;
      end
      wdog_d = run && state_d == state_q ? wdog_q + 1'b1 : '0;
`endif
      if (release_bank) begin
         full_d[rbank_q] = 1'b0;
         rbank_d         = ~rbank_q;
      end
      done_d = done_q | (state_d == DONE);
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         wptr_q      <= '0;
         wbank_q     <= 1'b0;
         rbank_q     <= 1'b0;
         full_q      <= '0;
         frame_cnt_q <= '0;
         done_q      <= 1'b0;
         overflow_q  <= 1'b0;
         fft_start_q <= 1'b0;
         ana_start_q <= 1'b0;
         fft_bank_q  <= 1'b0;
`ifdef FAS_SCHED_WDOG_EN
         wdog_q      <= '0;
         err_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         wptr_q      <= wptr_d;
         wbank_q     <= wbank_d;
         rbank_q     <= rbank_d;
         full_q      <= full_d;
         frame_cnt_q <= frame_cnt_d;
         done_q      <= done_d;
         overflow_q  <= overflow_d;
         fft_start_q <= fft_start_d;
         ana_start_q <= ana_start_d;
         fft_bank_q  <= fft_bank_d;
`ifdef FAS_SCHED_WDOG_EN
         wdog_q      <= wdog_d;
         err_q       <= err_d;
`endif
      end
   end
endmodule

// File: tb/tb_fas_sched.sv
// tb_fas_sched: directed scenarios plus randomized traffic checked against a frame-counting model.
module tb_fas_sched;
   localparam int NF  = 64;
   localparam int WDM = 255;
`ifdef FAS_SCHED_WDOG_EN
   localparam bit WD_EN = 1'b1;
`else
   localparam bit WD_EN = 1'b0;
`endif
   logic clk = 1'b0, rst = 1'b1, fir_valid = 1'b0, fft_done = 1'b0, ana_done = 1'b0;
   logic [15:0] fir_d = '0;
   logic buf_wr_en, fft_start, fft_bank, ana_start, done, overflow, err;
   logic [4:0] buf_wr_addr;
   logic [15:0] buf_wr_data;
   logic [6:0] frame_cnt;
   int n_tests = 0, n_fail = 0;
   int fdly = 0, adly = 0, fc = 0, ac = 0;
   bit rnd = 1'b0;
   int m_acc, m_cons, m_frames, m_wd, m_ph;
   bit m_fs, m_as, m_err, m_ovf, full_w, e_en;

   fas_sched #(.NUM_FRAMES(NF), .WDOG_MAX(WDM)) dut (
      .clk(clk), .rst(rst), .fir_valid(fir_valid), .fir_d(fir_d),
      .buf_wr_en(buf_wr_en), .buf_wr_addr(buf_wr_addr), .buf_wr_data(buf_wr_data),
      .fft_start(fft_start), .fft_bank(fft_bank), .fft_done(fft_done),
      .ana_start(ana_start), .ana_done(ana_done), .frame_cnt(frame_cnt),
      .done(done), .overflow(overflow), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit v, input logic [15:0] d);
      tick();
      fir_valid = v;
      fir_d = d;
      #1;
   endtask

   task automatic do_reset();
      tick();
      rst = 1'b1;
      fir_valid = 1'b0;
      repeat (2) tick();
      rst = 1'b0;
   endtask

   // Completion responder: pulses done a programmable number of cycles after each start.
   initial forever begin
      tick();
      fft_done = 1'b0;
      ana_done = 1'b0;
      if (rst) begin
         fc = 0;
         ac = 0;
      end else begin
         if (fc != 0) begin
            fc--;
            if (fc == 0) fft_done = 1'b1;
         end
         if (ac != 0) begin
            ac--;
            if (ac == 0) ana_done = 1'b1;
         end
         if (fft_start) fc = rnd ? int'($urandom_range(1, 8)) : fdly;
         if (ana_start) ac = rnd ? int'($urandom_range(1, 8)) : adly;
         if (rnd && $urandom_range(0, 15) == 0) fft_done = 1'b1;
         if (rnd && $urandom_range(0, 15) == 0) ana_done = 1'b1;
      end
   end

   task automatic wd_tick();
      if (WD_EN && m_wd == WDM - 1) begin
         m_err = 1'b1;
         m_cons++;
         m_ph = 0;
      end else m_wd++;
   endtask

   // Model: banks are implied by counts of accepted samples and consumed frames.
   initial forever begin
      @(negedge clk);
      if (rst) begin
         m_acc = 0; m_cons = 0; m_frames = 0; m_wd = 0; m_ph = 0;
         m_fs = 0; m_as = 0; m_err = 0; m_ovf = 0;
         chk("rst_wr_en", buf_wr_en, 0);
         chk("rst_wr_addr", buf_wr_addr, 0);
         chk("rst_fft_start", fft_start, 0);
         chk("rst_ana_start", ana_start, 0);
         chk("rst_fft_bank", fft_bank, 0);
         chk("rst_frame_cnt", frame_cnt, 0);
         chk("rst_done", done, 0);
         chk("rst_overflow", overflow, 0);
         chk("rst_err", err, 0);
      end else begin
         full_w = (m_acc / 16) - m_cons == 2;
         e_en = fir_valid && !full_w;
         chk("wr_en", buf_wr_en, e_en);
         if (e_en) begin
            chk("wr_addr", buf_wr_addr, m_acc % 32);
            chk("wr_data", buf_wr_data, fir_d);
         end
         chk("fft_start", fft_start, m_fs);
         chk("ana_start", ana_start, m_as);
         chk("err", err, m_err);
         chk("frame_cnt", frame_cnt, m_frames);
         chk("done", done, m_ph == 3);
         chk("overflow", overflow, m_ovf);
         if (m_ph == 1 || m_ph == 2) chk("fft_bank", fft_bank, m_cons % 2);
         m_ovf = m_ovf | (fir_valid && full_w);
         if (e_en) m_acc++;
         m_fs = 0; m_as = 0; m_err = 0;
         case (m_ph)
            0: if (m_acc / 16 > m_cons) begin
               m_ph = 1; m_fs = 1; m_wd = 0;
            end
            1: if (fft_done) begin
               m_ph = 2; m_as = 1; m_wd = 0;
            end else wd_tick();
            2: if (ana_done) begin
               m_cons++;
               m_frames++;
               m_ph = m_frames == NF ? 3 : 0;
            end else wd_tick();
            default: ;
         endcase
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1);
   end

   initial begin
      int lat, wr, ns;
      do_reset();
      chk("init_frame_cnt", frame_cnt, 0);
      chk("init_done", done, 0);
      chk("init_overflow", overflow, 0);
      chk("init_fft_start", fft_start, 0);
      // First frame and launch latency
      fdly = 20;
      adly = 5;
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, 16'h0100 + 16'(i));
         chk("s1_addr", buf_wr_addr, i);
         chk("s1_en", buf_wr_en, 1);
         chk("s1_data", buf_wr_data, 32'h0100 + i);
      end
      drive(1'b0, 16'h0);
      chk("s1_fft_start", fft_start, 1);
      chk("s1_fft_bank", fft_bank, 0);
      lat = 0;
      for (int k = 1; k <= 40 && lat == 0; k++) begin
         drive(1'b0, 16'h0);
         if (ana_start) lat = k;
      end
      chk("s2_ana_lat", lat, 21);
      lat = 0;
      for (int k = 1; k <= 20 && lat == 0; k++) begin
         drive(1'b0, 16'h0);
         if (frame_cnt == 7'd1) lat = k;
      end
      chk("s2_fc_lat", lat, 6);
      for (int i = 0; i < 32; i++) drive(1'b1, 16'($urandom));
      drive(1'b0, 16'h0);
      chk("s2_no_ovf", overflow, 0);
      // Stalled FFT: both banks fill, then samples drop
      do_reset();
      fdly = 0;
      adly = 0;
      wr = 0;
      for (int i = 0; i < 40; i++) begin
         drive(1'b1, 16'(i));
         if (buf_wr_en) wr++;
         if (i == 32) chk("s3_drop_en", buf_wr_en, 0);
      end
      drive(1'b0, 16'h0);
      chk("s3_writes", wr, 32);
      chk("s3_ovf", overflow, 1);
      // Full run to completion
      do_reset();
      fdly = 3;
      adly = 3;
      for (int i = 0; i < 1024; i++) drive(1'b1, 16'($urandom));
      for (int k = 0; k < 300 && !done; k++) drive(1'b0, 16'h0);
      chk("s4_frame_cnt", frame_cnt, NF);
      chk("s4_done", done, 1);
      chk("s4_ovf", overflow, 0);
      ns = 0;
      for (int i = 0; i < 40; i++) begin
         drive(1'b1, 16'($urandom));
         if (fft_start) ns++;
      end
      chk("s4_no_restart", ns, 0);
      chk("s4_done_sticky", done, 1);
      // Reset mid-frame
      do_reset();
      for (int i = 0; i < 24; i++) drive(1'b1, 16'(i));
      tick();
      rst = 1'b1;
      fir_valid = 1'b0;
      #1;
      chk("s5_frame_cnt", frame_cnt, 0);
      chk("s5_fft_start", fft_start, 0);
      chk("s5_ana_start", ana_start, 0);
      chk("s5_overflow", overflow, 0);
      chk("s5_wr_addr", buf_wr_addr, 0);
      repeat (2) tick();
      rst = 1'b0;
      drive(1'b1, 16'h55aa);
      chk("s5_first_addr", buf_wr_addr, 0);
      chk("s5_first_en", buf_wr_en, 1);
      // Randomized traffic with spurious completions and occasional resets
      rnd = 1'b1;
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 699) == 0) begin
            tick();
            rst = 1'b1;
            fir_valid = 1'b0;
            tick();
            rst = 1'b0;
         end else drive($urandom_range(0, 3) != 0, 16'($urandom));
      end
      rnd = 1'b0;
`ifdef FAS_SCHED_WDOG_EN
      do_reset();
      fdly = 0;
      adly = 0;
      for (int i = 0; i < 16; i++) drive(1'b1, 16'(i));
      drive(1'b0, 16'h0);
      chk("wd_fft_start", fft_start, 1);
      lat = 0;
      for (int k = 1; k <= 300 && lat == 0; k++) begin
         drive(1'b0, 16'h0);
         if (err) lat = k;
      end
      chk("wd_lat", lat, WDM);
      chk("wd_frame_cnt", frame_cnt, 0);
      drive(1'b0, 16'h0);
      chk("wd_err_pulse", err, 0);
`endif
      repeat (4) drive(1'b0, 16'h0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
